rfphoenix_tlb_walker: RTL and testbench

// Hardware page-table walker sitting between the TLB miss outputs and the TLB update port. On a

---
 rtl/rfphoenix_tlb_walker.sv | 140 ++++++++++++++
 tb/tb_rfphoenix_tlb_walker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_tlb_walker.sv
// rfphoenix_tlb_walker: two-level hardware page-table walker feeding the TLB update port
// Ports: clk_i/rst_i (sync active-high); tlbmiss_i/tlbmiss_adr_i/asid_i/ptbr_i start a walk;
// m_cyc_o/m_adr_o/m_ack_i/m_dat_i single-beat read master; tlb_wr_o/tlb_adr_o/tlb_dat_o TLB write;
// busy_o, fault_o pulse with held fault_cause_o (1=L1 inv, 2=L2 inv, 3=timeout) and fault_adr_o.
// TLBE layout (tlb_dat_o, 128 bits, msb first): 32'0, adr[31:0], vpn[18:0], ppn[18:0], asid[9:0],
// 9'0, c, rwx[2:0], m, g, v.
module rfphoenix_tlb_walker #(
  parameter int HOLD_CYC = 4,
  parameter int TMO_CYC  = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tlbmiss_i,
  input  logic [31:0]  tlbmiss_adr_i,
  input  logic [9:0]   asid_i,
  input  logic [31:0]  ptbr_i,
  output logic         m_cyc_o,
  output logic [31:0]  m_adr_o,
  input  logic         m_ack_i,
  input  logic [63:0]  m_dat_i,
  output logic         tlb_wr_o,
  output logic [15:0]  tlb_adr_o,
  output logic [127:0] tlb_dat_o,
  output logic         busy_o,
  output logic         fault_o,
  output logic [1:0]   fault_cause_o,
  output logic [31:0]  fault_adr_o
);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 2);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_L1   = 3'd1;
  localparam logic [2:0] S_L2R  = 3'd2;
  localparam logic [2:0] S_L2   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;
  localparam logic [2:0] S_FLT  = 3'd6;
  logic [2:0]   st_q, st_d;
  logic [31:0]  va_q, va_d, m_adr_q, m_adr_d, fadr_q, fadr_d;
  logic [9:0]   asid_q, asid_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]  tlb_adr_q, tlb_adr_d;
  logic [127:0] tlb_dat_q, tlb_dat_d;
  logic [1:0]   cause_q, cause_d;
  logic         unused;
  assign unused = ^{m_dat_i[63:32], m_dat_i[12:7], va_q[12:0]};
  // Strobes are decoded from state so a reset drops them at the reset edge.
  assign m_cyc_o       = (st_q == S_L1) || (st_q == S_L2);
  assign tlb_wr_o      = st_q == S_WR;
  assign fault_o       = st_q == S_FLT;
  assign busy_o        = st_q != S_IDLE;
  assign m_adr_o       = m_adr_q;
  assign tlb_adr_o     = tlb_adr_q;
  assign tlb_dat_o     = tlb_dat_q;
  assign fault_cause_o = cause_q;
  assign fault_adr_o   = fadr_q;
  always_comb begin
    st_d      = st_q;
    va_d      = va_q;
    asid_d    = asid_q;
    m_adr_d   = m_adr_q;
    tmo_d     = tmo_q;
    hold_d    = hold_q;
    tlb_adr_d = tlb_adr_q;
    tlb_dat_d = tlb_dat_q;
    cause_d   = cause_q;
    fadr_d    = fadr_q;
    case (st_q)
      S_IDLE: if (tlbmiss_i) begin
        va_d    = tlbmiss_adr_i;
        asid_d  = asid_i;
        m_adr_d = ptbr_i + {20'd0, tlbmiss_adr_i[31:23], 3'b000};
        tmo_d   = '0;
        st_d    = S_L1;
      end
      S_L1, S_L2: if (m_ack_i) begin
        if (!m_dat_i[0]) begin
          cause_d = (st_q == S_L1) ? 2'd1 : 2'd2;
          fadr_d  = va_q;
          st_d    = S_FLT;
        end else if (st_q == S_L1) begin
          m_adr_d = {m_dat_i[31:13], 13'd0} + {19'd0, va_q[22:13], 3'b000};
          st_d    = S_L2R;
        end else begin
          tlb_dat_d = {32'd0, m_adr_q, va_q[31:13], m_dat_i[31:13], asid_q, 9'd0,
                       m_dat_i[6], m_dat_i[5:3], m_dat_i[2], m_dat_i[1], 1'b1};
          tlb_adr_d = {va_q[23:13], 5'd0};
          st_d      = S_WR;
        end
      end else begin
        // An ack arriving on the final wait cycle is taken above, so it beats the timeout.
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TW'(TMO_CYC - 1)) begin
          cause_d = 2'd3;
          fadr_d  = va_q;
          st_d    = S_FLT;
        end
      end
      S_L2R: begin
        tmo_d = '0;
        st_d  = S_L2;
      end
      S_WR, S_FLT: begin
        hold_d = HW'(HOLD_CYC);
        st_d   = S_HOLD;
      end
      S_HOLD: begin
        hold_d = (hold_q == '0) ? hold_q : hold_q - 1'b1;
        st_d   = (hold_q == '0) ? S_IDLE : S_HOLD;
      end
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q      <= S_IDLE;
      va_q      <= '0;
      asid_q    <= '0;
      m_adr_q   <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      tlb_adr_q <= '0;
      tlb_dat_q <= '0;
      cause_q   <= '0;
      fadr_q    <= '0;
    end else begin
      st_q      <= st_d;
      va_q      <= va_d;
      asid_q    <= asid_d;
      m_adr_q   <= m_adr_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      tlb_adr_q <= tlb_adr_d;
      tlb_dat_q <= tlb_dat_d;
      cause_q   <= cause_d;
      fadr_q    <= fadr_d;
    end
  end
endmodule

// File: tb/tb_rfphoenix_tlb_walker.sv
// tb_rfphoenix_tlb_walker: directed bench for the page-table walker
module tb_rfphoenix_tlb_walker;
  logic         clk_i = 1'b0, rst_i = 1'b1, tlbmiss_i = 1'b0;
  logic [31:0]  tlbmiss_adr_i = '0, ptbr_i = 32'h1000;
  logic [9:0]   asid_i = 10'h2A5;
  logic         m_cyc_o, m_ack_i, tlb_wr_o, busy_o, fault_o;
  logic [31:0]  m_adr_o, fault_adr_o;
  logic [63:0]  m_dat_i;
  logic [15:0]  tlb_adr_o;
  logic [127:0] tlb_dat_o;
  logic [1:0]   fault_cause_o;
  logic         ack_en = 1'b1, ack_force = 1'b0;
  logic [31:0]  stall_adr = 32'hFFFF_FFFF;
  logic [31:0]  t_adr [4] = '{32'h1008, 32'h4008, 32'h1FF8, 32'h2000};
  logic [63:0]  t_dat [4] = '{64'h4001, 64'h3E02B, 64'h0, 64'h0};
  int rd_cnt = 0, wr_cnt = 0, flt_cnt = 0, n_chk = 0, n_pass = 0;
  logic [31:0] rd_log [$];
  rfphoenix_tlb_walker dut (
    .clk_i(clk_i), .rst_i(rst_i), .tlbmiss_i(tlbmiss_i), .tlbmiss_adr_i(tlbmiss_adr_i),
    .asid_i(asid_i), .ptbr_i(ptbr_i), .m_cyc_o(m_cyc_o), .m_adr_o(m_adr_o), .m_ack_i(m_ack_i),
    .m_dat_i(m_dat_i), .tlb_wr_o(tlb_wr_o), .tlb_adr_o(tlb_adr_o), .tlb_dat_o(tlb_dat_o),
    .busy_o(busy_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o), .fault_adr_o(fault_adr_o)
  );
  always #5 clk_i = ~clk_i;
  always_comb begin
    m_dat_i = '0;
    for (int i = 0; i < 4; i++) if (t_adr[i] == m_adr_o) m_dat_i = t_dat[i];
  end
  assign m_ack_i = ack_force | (m_cyc_o & ack_en & (m_adr_o != stall_adr));
  always @(posedge clk_i) begin
    if (m_cyc_o && m_ack_i) begin
      rd_cnt++;
      rd_log.push_back(m_adr_o);
    end
    if (tlb_wr_o) wr_cnt++;
    if (fault_o) flt_cnt++;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic pulse_miss(input logic [31:0] va);
    tlbmiss_adr_i = va;
    tlbmiss_i = 1'b1;
    @(negedge clk_i);
    tlbmiss_i = 1'b0;
  endtask
  task automatic wait_fault(input string tag);
    int k = 0;
    while (!fault_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, fault_o, 1'b1);
  endtask
  task automatic wait_wr(input string tag);
    int k = 0;
    while (!tlb_wr_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, tlb_wr_o, 1'b1);
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_o && k < 600) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, busy_o, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int base, lat, n, k;
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cyc", m_cyc_o, 1'b0);
    check("rst_madr", m_adr_o, 32'h0);
    check("rst_wr", tlb_wr_o, 1'b0);
    check("rst_tlbadr", tlb_adr_o, 16'h0);
    check("rst_tlbdat", tlb_dat_o, 128'h0);
    check("rst_fault", fault_o, 1'b0);
    check("rst_cause", fault_cause_o, 2'd0);
    check("rst_fadr", fault_adr_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    base = rd_cnt;
    tlbmiss_adr_i = 32'h0080_2000;
    tlbmiss_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!tlb_wr_o && lat < 20);
    tlbmiss_i = 1'b0;
    check("t1_latency", lat, 4);
    check("t1_reads", rd_cnt - base, 2);
    check("t1_l1_adr", rd_log[base], 32'h1008);
    check("t1_l2_adr", rd_log[base+1], 32'h4008);
    check("t1_tlbadr", tlb_adr_o, 16'h8020);
    check("t1_tlbdat", tlb_dat_o, {32'd0, 32'h4008, 19'h401, 19'h1F, 10'h2A5, 9'd0,
                                   1'b0, 3'd5, 1'b0, 1'b1, 1'b1});
    @(negedge clk_i);
    check("t1_wr_pulse", tlb_wr_o, 1'b0);
    wait_idle("t1_idle");
    check("t1_wr_cnt", wr_cnt, 1);
    pulse_miss(32'hFFFC_0000);
    wait_fault("t2_fault");
    check("t2_cause", fault_cause_o, 2'd1);
    check("t2_fadr", fault_adr_o, 32'hFFFC_0000);
    check("t2_l1_adr", rd_log[rd_log.size()-1], 32'h1FF8);
    @(negedge clk_i);
    check("t2_pulse", fault_o, 1'b0);
    wait_idle("t2_idle");
    check("t2_no_wr", wr_cnt, 1);
    check("t2_flt_cnt", flt_cnt, 1);
    t_dat[1] = 64'h3E02A;
    base = rd_cnt;
    pulse_miss(32'h0080_2000);
    wait_fault("t3_fault");
    check("t3_cause", fault_cause_o, 2'd2);
    wait_idle("t3_idle");
    check("t3_reads", rd_cnt - base, 2);
    check("t3_flt_cnt", flt_cnt, 2);
    check("t3_no_wr", wr_cnt, 1);
    ack_en = 1'b0;
    base = rd_cnt;
    pulse_miss(32'h0080_2000);
    n = 0;
    while (m_cyc_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check("t4_cyc_len", n, 255);
    check("t4_fault", fault_o, 1'b1);
    check("t4_cause", fault_cause_o, 2'd3);
    check("t4_reads", rd_cnt - base, 0);
    ack_en = 1'b1;
    wait_idle("t4_idle");
    check("t4_flt_cnt", flt_cnt, 3);
    t_dat[1] = 64'h3E02B;
    tlbmiss_adr_i = 32'h0080_2000;
    tlbmiss_i = 1'b1;
    wait_wr("t5_wr1");
    n = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (m_cyc_o) n++;
    end
    check("t5_hold_quiet", n, 0);
    k = 0;
    while (!m_cyc_o && k < 10) begin
      @(negedge clk_i);
      k++;
    end
    check("t5_rewalk", m_cyc_o, 1'b1);
    wait_wr("t5_wr2");
    tlbmiss_i = 1'b0;
    wait_idle("t5_idle");
    check("t5_wr_cnt", wr_cnt, 3);
    stall_adr = 32'h4008;
    pulse_miss(32'h0080_2000);
    k = 0;
    while (!(m_cyc_o && m_adr_o == 32'h4008) && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check("t6_l2_pending", m_cyc_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t6_cyc_rst", m_cyc_o, 1'b0);
    check("t6_busy_rst", busy_o, 1'b0);
    rst_i = 1'b0;
    stall_adr = 32'hFFFF_FFFF;
    ack_force = 1'b1;
    repeat (2) @(negedge clk_i);
    ack_force = 1'b0;
    repeat (3) @(negedge clk_i);
    check("t6_busy", busy_o, 1'b0);
    check("t6_cyc", m_cyc_o, 1'b0);
    check("t6_no_wr", wr_cnt, 3);
    check("t6_no_flt", flt_cnt, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
